game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Central game-flow controller for the frog/car VGA game.
- Owns game state (idle, play, hit, level-up, game over), lives and level.
- Derives a once-per-frame tick from the VGA counters and schedules car motion as step pulses whose rate scales with level.
- Commands player respawn and freezes the playfield between rounds; sits between vga_control, player_control and car_control.

Parameters:
- LIVES_INIT, 3: lives loaded at reset and at new game (1..4).
- MAX_LEVEL, 7: level saturates here (fits 3 bits).
- BASE_PERIOD, 8: frames per car step at level 0.
- HIT_FRAMES, 60: frames frozen after a collision.
- WIN_FRAMES, 60: frames frozen after reaching the goal.
- V_ACTIVE, 480: first non-visible line; frame tick line.

Ports:
- CLK  in  1  system clock (25 MHz pixel clock)
- RST  in  1  synchronous, active-high reset
- h_count  in  10  VGA horizontal counter
- v_count  in  10  VGA vertical counter
- i_any_sw  in  1  OR of SW1..SW4, already debounced
- i_collision  in  1  player/car overlap, level-sensitive
- i_goal  in  1  player reached top row, level-sensitive
- o_frame_tick  out  1  one-cycle pulse per frame
- o_car_step  out  1  one-cycle pulse: cars advance one step
- o_player_respawn  out  1  one-cycle pulse: player returns to start
- o_freeze  out  1  high = player input and car motion disabled
- o_state  out  3  current state encoding
- o_lives  out  3  remaining lives
- o_level  out  3  current level
- o_lives_leds  out  4  thermometer display of lives (LED1..LED4)

Behaviour:
- All outputs registered. CLK is the only clock. RST is synchronous and active-high.
- Reset values:
  - state=IDLE, lives=LIVES_INIT, level=0.
  - frame_tick, car_step, respawn = 0; freeze=1.
  - Frame and step counters = 0.
  - sw_prev=1, so a switch held through reset does not start a game.
  - o_lives_leds reflects LIVES_INIT on the cycle after reset.
- Frame tick: o_frame_tick=1 for exactly one cycle, the cycle after h_count==0 && v_count==V_ACTIVE is sampled.
- Start edge: start = i_any_sw & ~sw_prev; sw_prev is updated every cycle.
- States and transitions (each takes effect one cycle after the input is sampled):
  - IDLE: on start -> PLAY; pulse respawn; freeze=0.
  - PLAY: i_collision -> HIT; lives decrements, saturating at 0. Otherwise i_goal -> LEVEL_UP. If both are asserted in the same cycle, collision wins.
  - HIT: freeze=1; count HIT_FRAMES frame ticks. Then lives==0 -> GAME_OVER; otherwise -> PLAY with respawn pulse and freeze=0.
  - LEVEL_UP: freeze=1; count WIN_FRAMES frame ticks. Then level=min(level+1, MAX_LEVEL), respawn pulse, -> PLAY. Lives are unchanged.
  - GAME_OVER: freeze=1; on start -> IDLE, with lives=LIVES_INIT and level=0.
  - Inputs i_collision and i_goal are ignored outside PLAY.
- Car scheduling:
  - period = max(BASE_PERIOD - level, 1), computed unsigned with no wrap.
  - In PLAY, each frame tick increments step_cnt. When step_cnt+1 >= period: o_car_step=1 on the same cycle as o_frame_tick, and step_cnt=0.
  - The >= compare handles a period that shrank while counting.
  - step_cnt clears on every entry to PLAY. o_car_step is never asserted outside PLAY.
- Frame counter: clears on entry to HIT/LEVEL_UP and counts only on frame ticks.
- o_lives_leds[i] = (lives > i).
- RST asserted mid-operation returns to IDLE on the next edge with all reset values, regardless of state.

Decomposition:
- Shared constants (in constants.v):
  - State encodings: IDLE=0, PLAY=1, HIT=2, LEVEL_UP=3, GAME_OVER=4.
  - V_ACTIVE, LIVES_INIT, MAX_LEVEL.
- One natural sub-module: frame_divider, containing the frame-tick detect plus the programmable-period step counter (inputs: enable, clear, period; outputs: tick, step).
- The FSM, lives and level logic stay in game_sequencer.

Test Plan:
- Bench parameters: HIT_FRAMES=2, WIN_FRAMES=2, BASE_PERIOD=3, with VGA counters driven by a behavioural 800x525 scan.
- Reset with i_any_sw held high -> state stays IDLE until release then re-press; lives=3, leds=0111, freeze=1.
- Start press -> next cycle state=PLAY, respawn pulse one cycle wide, freeze=0. At level 0, car_step fires on every 3rd frame tick, coincident with frame_tick.
- i_collision and i_goal asserted together in PLAY -> state=HIT, lives 3->2, leds=0011. After 2 frame ticks: PLAY plus respawn, level still 0.
- i_goal in PLAY -> LEVEL_UP; after 2 ticks level=1, period=2, car_step every 2nd tick. Repeat to level 7 -> period clamps at 1 (step every tick) and level holds at 7.
- Three collisions -> lives 0, leds=0000, GAME_OVER. Press -> IDLE with lives=3, level=0.
- RST pulsed for one cycle mid-HIT -> IDLE next edge, counters 0, no car_step or respawn pulse.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared state encodings, default sizing constants and the lives-to-LED helper
// used by the game-flow controller and its frame divider.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_LIVES_INIT = 3;
    localparam int DEF_MAX_LEVEL  = 7;

    // Thermometer code: LED i is lit while more than i lives remain.
    function automatic logic [3:0] lives_to_leds(input logic [2:0] lives);
        logic [3:0] leds;
        for (int i = 0; i < 4; i++) begin
            leds[i] = (lives > 3'(i));
        end
        return leds;
    endfunction

endpackage

// File: rtl/game_sequencer_frame_divider.sv
// Once-per-frame tick from the VGA counters, plus a programmable-period
// counter that turns frame ticks into car step pulses while enabled.
module game_sequencer_frame_divider #(
    parameter int V_ACTIVE = 480,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                srst,
    input  logic [9:0]          h_count,
    input  logic [9:0]          v_count,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick,
    output logic                step
);

    localparam logic [9:0] TICK_LINE = 10'(V_ACTIVE);

    logic                tick_q, tick_d;
    logic                step_q, step_d;
    logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
    logic                line_hit;

    always_comb begin
        line_hit   = (h_count == 10'd0) && (v_count == TICK_LINE);
        tick_d     = line_hit;
        step_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        if (clear) begin
            step_cnt_d = '0;
        end else if (enable && line_hit) begin
            // >= rather than == so a period that shrank mid-count still fires
            if (({1'b0, step_cnt_q} + 1'b1) >= {1'b0, period}) begin
                step_d     = 1'b1;
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tick_q     <= 1'b0;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            tick_q     <= tick_d;
            step_q     <= step_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign tick = tick_q;
    assign step = step_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: owns state, lives and level, freezes the playfield
// between rounds and schedules car steps whose rate rises with the level.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int LIVES_INIT  = DEF_LIVES_INIT,
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int BASE_PERIOD = 8,
    parameter int HIT_FRAMES  = 60,
    parameter int WIN_FRAMES  = 60,
    parameter int V_ACTIVE    = DEF_V_ACTIVE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic       i_any_sw,
    input  logic       i_collision,
    input  logic       i_goal,
    output logic       o_frame_tick,
    output logic       o_car_step,
    output logic       o_player_respawn,
    output logic       o_freeze,
    output logic [2:0] o_state,
    output logic [2:0] o_lives,
    output logic [2:0] o_level,
    output logic [3:0] o_lives_leds
);

    localparam int PERIOD_W = 8;

    state_t              state_q, state_d;
    logic [2:0]          lives_q, lives_d;
    logic [2:0]          level_q, level_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                respawn_q, respawn_d;
    logic                freeze_q, freeze_d;
    logic                sw_prev_q;
    logic [3:0]          leds_q, leds_d;
    logic                start;
    logic                frame_tick;
    logic                car_step;
    logic                step_enable;
    logic                step_clear;
    logic [PERIOD_W-1:0] period;

    always_comb begin
        if (BASE_PERIOD > int'(level_q)) period = PERIOD_W'(BASE_PERIOD - int'(level_q));
        else                             period = PERIOD_W'(1);
    end

    always_comb begin
        start       = i_any_sw & ~sw_prev_q;
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        respawn_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PLAY;
                    respawn_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (i_collision) begin
                    state_d     = ST_HIT;
                    lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    frame_cnt_d = '0;
                end else if (i_goal) begin
                    state_d     = ST_LEVEL_UP;
                    frame_cnt_d = '0;
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (int'(frame_cnt_q) + 1 >= HIT_FRAMES) begin
                        if (lives_q == 3'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d   = ST_PLAY;
                            respawn_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            ST_LEVEL_UP: begin
                if (frame_tick) begin
                    if (int'(frame_cnt_q) + 1 >= WIN_FRAMES) begin
                        state_d   = ST_PLAY;
                        respawn_d = 1'b1;
                        level_d   = (int'(level_q) >= MAX_LEVEL) ? 3'(MAX_LEVEL) : level_q + 3'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    state_d = ST_IDLE;
                    lives_d = 3'(LIVES_INIT);
                    level_d = 3'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d = (state_d != ST_PLAY);
        leds_d   = lives_to_leds(lives_d);
    end

    // Steps only on cycles that stay in PLAY, so no step lands on an exit cycle.
    assign step_enable = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    assign step_clear  = (state_q != ST_PLAY) && (state_d == ST_PLAY);

    game_sequencer_frame_divider #(
        .V_ACTIVE (V_ACTIVE),
        .PERIOD_W (PERIOD_W)
    ) u_frame_divider (
        .clk     (CLK),
        .srst    (RST),
        .h_count (h_count),
        .v_count (v_count),
        .enable  (step_enable),
        .clear   (step_clear),
        .period  (period),
        .tick    (frame_tick),
        .step    (car_step)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            lives_q     <= 3'(LIVES_INIT);
            level_q     <= 3'd0;
            frame_cnt_q <= '0;
            respawn_q   <= 1'b0;
            freeze_q    <= 1'b1;
            sw_prev_q   <= 1'b1;
            leds_q      <= lives_to_leds(3'(LIVES_INIT));
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            respawn_q   <= respawn_d;
            freeze_q    <= freeze_d;
            sw_prev_q   <= i_any_sw;
            leds_q      <= leds_d;
        end
    end

    assign o_frame_tick     = frame_tick;
    assign o_car_step       = car_step;
    assign o_player_respawn = respawn_q;
    assign o_freeze         = freeze_q;
    assign o_state          = state_q;
    assign o_lives          = lives_q;
    assign o_level          = level_q;
    assign o_lives_leds     = leds_q;

endmodule
